// File: rtl/reg_load_sched_pkg.sv
// reg_load_sched_pkg: shared FSM state, counter width and staging record for reg_load_sched
package reg_load_sched_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, COMMIT = 1'b1} state_t;
  localparam int CNT_W = 16;
  localparam int STG_AW = 8;
  localparam int STG_DW = 64;
  localparam int STG_IW = 3;
  typedef struct packed {
    logic [STG_AW-1:0] addr;
    logic [STG_DW-1:0] data;
    logic [STG_IW-1:0] id;
  } stage_t;
endpackage

// File: rtl/reg_load_arb.sv
// reg_load_arb: combinational one-hot arbiter; round-robin from ptr when REG_LOAD_SCHED_RR_EN, else lowest index wins
module reg_load_arb #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] j;
`ifdef REG_LOAD_SCHED_RR_EN
  // scan from lowest priority to highest so the last hit is the winner
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (valid[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'(k);
      if (valid[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
`endif
endmodule

// File: rtl/reg_load_sched.sv
// reg_load_sched: serialises register-bank writes, one grant per two cycles via IDLE/COMMIT staging
// Define REG_LOAD_SCHED_RR_EN for round-robin arbitration; fixed priority otherwise.
module reg_load_sched
  import reg_load_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int AW = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREG*WIDTH-1:0]   q,
  output logic                    busy,
  output logic                    wr_done,
  output logic                    wr_err,
  output logic [$clog2(NREQ)-1:0] wr_id,
  output logic [CNT_W-1:0]        wr_count
);
  localparam int IW = $clog2(NREQ);
  state_t state;
  stage_t stage;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] idx, ptr;
  logic [CNT_W-1:0] cnt;
  logic addr_ok, unused_stage;
  reg_load_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .valid(req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(idx)
  );
  assign busy = state == COMMIT;
  assign addr_ok = stage.addr < STG_AW'(NREG);
  // a low reset during COMMIT aborts the write, so the pulses are suppressed too
  assign wr_done = busy && addr_ok && reset;
  assign wr_err = busy && !addr_ok && reset;
  assign req_ready = busy ? '0 : grant;
  assign wr_id = stage.id[IW-1:0];
  assign wr_count = cnt;
  assign unused_stage = ^{stage.data, stage.id};
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      stage <= '0;
      cnt <= '0;
    end else if (busy) begin
      state <= IDLE;
      cnt <= cnt + CNT_W'(wr_done);
    end else if (|req_valid) begin
      state <= COMMIT;
      stage <= '{addr: STG_AW'(req_addr[idx*AW +: AW]),
                 data: STG_DW'(req_data[idx*WIDTH +: WIDTH]),
                 id: STG_IW'(idx)};
    end
`ifdef REG_LOAD_SCHED_RR_EN
  always_ff @(posedge clk)
    if (!reset) ptr <= '0;
    else if (!busy && |req_valid) ptr <= idx == IW'(NREQ - 1) ? '0 : idx + 1'b1;
`else
  assign ptr = '0;
`endif
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge clk)
      if (!reset) r_q <= '0;
      else if (wr_done && stage.addr == STG_AW'(r)) r_q <= stage.data[WIDTH-1:0];
    assign q[r*WIDTH +: WIDTH] = r_q;
  end
endmodule
